key_hit_judge: RTL and testbench
================================

# key_hit_judge

Player-side responder for the LED prompt interface. The LED generator drives a 4-bit prompt and this block judges it: it synchronises and debounces the four active-low push buttons and opens a timed response window for each new prompt. It then judges the player's key presses against the latched target and keeps a two-digit BCD score for the HEX display path. It sits in the datapath beside the LED generator and countdown timer, and is gated by the control FSM.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 500000: consecutive stable cycles needed to accept a key level (10 ms at 50 MHz); must be ≥1.
- WINDOW_CYCLES, default 50000000: response window length in clk cycles (1 s); must be ≥2.

Ports:
- clk  input  1  system clock (CLOCK_50 at top level).
- resetn  input  1  asynchronous, active-low reset.
- keys_n  input  4  raw push buttons, active-low (board KEY[3:0]), asynchronous to clk.
- game_enable  input  1  high while the control FSM is in the play state.
- prompt_new  input  1  single-cycle strobe: a new prompt is valid on prompt.
- prompt  input  4  target LED mask from the LED generator.
- score_clear  input  1  synchronous clear of the score and FSM.
- hit  output  1  single-cycle pulse on a successful judgement.
- miss  output  1  single-cycle pulse on a failed judgement.
- armed  output  1  high while a response window is open.
- score_1s_digit  output  4  BCD ones digit, 0–9.
- score_10s_digit  output  4  BCD tens digit, 0–9.

## Operation
- Input conditioning, per key:
  - 2-flop synchroniser.
  - Debounce counter: the stable level updates only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - A press event is a one-cycle pulse when the stable level goes 1→0. Releases generate no event.
- FSM states: IDLE, ARMED, JUDGED.
  - IDLE: on prompt_new with prompt≠0, latch the target, clear the accumulated mask acc, load the window counter with WINDOW_CYCLES−1, and go to ARMED. A prompt of 0000 is ignored.
  - ARMED: OR each press event into acc.
    - If any pressed key is outside the target: miss, go to JUDGED.
    - If (acc | presses) equals the target: hit, go to JUDGED.
    - If the window counter reaches 0 with no judgement: miss, go to JUDGED.
    - Otherwise, decrement the counter.
  - JUDGED: wait for the next prompt_new with prompt≠0, then re-arm as in IDLE. A prompt of 0000 goes to IDLE.
- Simultaneous events:
  - Hit and window expiry in the same cycle: hit wins.
  - prompt_new while ARMED: the current target is judged first in that cycle.
    - If this cycle's presses complete it: hit.
    - If a press is outside the target: miss.
    - Otherwise: miss, because the prompt was abandoned.
    - Then the FSM re-arms with the new prompt. hit/miss still pulse exactly once.
  - A wrong key and completion in the same cycle: miss.
- game_enable low: FSM is forced to IDLE, press events are ignored, no hit/miss pulses, score is held.
- score_clear: score goes to 00 and FSM to IDLE next edge. It overrides a hit or miss in the same cycle, and no pulse is emitted.
- Score: BCD. On a hit, increment; 9 in the ones digit carries to the tens digit. Saturates at 99.
- Reset: all outputs 0, FSM IDLE, debounced levels 1 (released), counters 0.

## Timing
- Press latency: the press event asserts DEBOUNCE_CYCLES+3 rising edges after the first edge that samples keys_n low (2 sync + DEBOUNCE_CYCLES + 1 edge detect), with the key held throughout.
- The prompt_new edge is cycle 0. armed is high from cycle 1.
- With no presses, miss pulses in cycle WINDOW_CYCLES and armed drops in the same cycle.
- hit/miss are registered and pulse the cycle after the deciding event; the score updates in that same cycle.
- resetn assertion clears everything immediately, including mid-window. Deassertion is synchronised by the top level.

## Configuration
- KEY_HIT_JUDGE_MISS_PENALTY_EN:
  - Defined: each miss decrements the BCD score (borrow from tens; saturates at 00). When miss coincides with score_clear, the clear wins.
  - Undefined: misses only pulse miss, and the score is unaffected.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, WINDOW_CYCLES=100.
- Single hit: prompt=0010 strobe, then press KEY[1] clean at cycle 10 → press at cycle 17, hit pulse at 18, score 01, armed low.
- Bounce: KEY[0] toggles every 2 cycles for 20 cycles then holds low → exactly one press event, 7 cycles after the hold begins. No event during bounce.
- Chord: prompt=1111, keys pressed on 4 separate cycles inside the window → one hit after the fourth press, score +1. A wrong key (prompt=0001, press KEY[2]) → miss, and score is unchanged (or decremented from 05 to 04 with the macro defined).
- Timeout and overlap: no press for 100 cycles → miss at cycle 100. A second prompt_new at cycle 50 of a window → miss for the old prompt, armed stays high, and the window restarts.
- Saturation and carry: 99 consecutive hits → score 99, the next hit holds 99, and 09→10 carries correctly. With the macro defined, a miss at 00 holds 00.
- Reset and clear: resetn low mid-window → outputs 0 immediately. score_clear coinciding with a completing press → score 00 and no hit pulse. game_enable low → presses are ignored.

Source files
------------

// File: rtl/key_hit_judge.sv
// key_hit_judge: debounces four active-low keys, judges presses against a latched LED prompt
// inside a timed window and keeps a saturating BCD score. Optional: KEY_HIT_JUDGE_MISS_PENALTY_EN.
module key_hit_judge #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int WINDOW_CYCLES   = 50000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] keys_n,
  input  logic       game_enable,
  input  logic       prompt_new,
  input  logic [3:0] prompt,
  input  logic       score_clear,
  output logic       hit,
  output logic       miss,
  output logic       armed,
  output logic [3:0] score_1s_digit,
  output logic [3:0] score_10s_digit
);

  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WINW = $clog2(WINDOW_CYCLES + 1);
  localparam logic [DBW-1:0]  DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DBW-1:0]  DB_ONE   = DBW'(1);
  localparam logic [WINW-1:0] WIN_LOAD = WINW'(WINDOW_CYCLES - 1);
  localparam logic [WINW-1:0] WIN_ONE  = WINW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    JUDGED = 2'd2
  } state_t;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h00) begin
      r = v;
    end else if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  logic [3:0]     sync1_r, sync2_r, stable_r, stable_d_r, press_r;
  logic [DBW-1:0] db_cnt_r [4];

  state_t          state_r, state_s;
  logic [3:0]      target_r, target_s, acc_r, acc_s;
  logic [WINW-1:0] win_r, win_s;
  logic [7:0]      score_r, score_s;
  logic            hit_s, miss_s, new_ok_s, wrong_s, done_s;
  logic            hit_r, miss_r, armed_r;

  // Two-flop synchroniser; idle level is released.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_r <= 4'b1111;
      sync2_r <= 4'b1111;
    end else begin
      sync1_r <= keys_n;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: any cycle matching the stable level restarts the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 4; k++) begin
        db_cnt_r[k] <= '0;
      end
      stable_r <= 4'b1111;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (sync2_r[k] == stable_r[k]) begin
          db_cnt_r[k] <= '0;
        end else if (db_cnt_r[k] == DB_LAST) begin
          db_cnt_r[k] <= '0;
          stable_r[k] <= sync2_r[k];
        end else begin
          db_cnt_r[k] <= db_cnt_r[k] + DB_ONE;
        end
      end
    end
  end

  // Registered 1->0 edge detect produces the one-cycle press events.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stable_d_r <= 4'b1111;
      press_r    <= 4'b0000;
    end else begin
      stable_d_r <= stable_r;
      press_r    <= stable_d_r & ~stable_r;
    end
  end

  // Judge FSM; a new prompt while armed first closes the old target, then re-arms.
  always_comb begin
    state_s  = state_r;
    target_s = target_r;
    acc_s    = acc_r;
    win_s    = win_r;
    hit_s    = 1'b0;
    miss_s   = 1'b0;
    new_ok_s = prompt_new && (prompt != 4'b0000);
    wrong_s  = (press_r & ~target_r) != 4'b0000;
    done_s   = (acc_r | press_r) == target_r;
    if (score_clear) begin
      state_s = IDLE;
    end else if (!game_enable) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (new_ok_s) begin
            state_s  = ARMED;
            target_s = prompt;
            acc_s    = 4'b0000;
            win_s    = WIN_LOAD;
          end else begin
            state_s = IDLE;
          end
        end
        ARMED: begin
          acc_s = acc_r | press_r;
          if (wrong_s) begin
            miss_s = 1'b1;
          end else if (done_s) begin
            hit_s = 1'b1;
          end else if (prompt_new || (win_r == WIN_ONE)) begin
            miss_s = 1'b1;
          end else begin
            win_s = win_r - WIN_ONE;
          end
          if (new_ok_s) begin
            state_s  = ARMED;
            target_s = prompt;
            acc_s    = 4'b0000;
            win_s    = WIN_LOAD;
          end else if (prompt_new) begin
            state_s = IDLE;
          end else if (hit_s || miss_s) begin
            state_s = JUDGED;
          end else begin
            state_s = ARMED;
          end
        end
        JUDGED: begin
          if (new_ok_s) begin
            state_s  = ARMED;
            target_s = prompt;
            acc_s    = 4'b0000;
            win_s    = WIN_LOAD;
          end else if (prompt_new) begin
            state_s = IDLE;
          end else begin
            state_s = JUDGED;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Score update; clear has priority and already suppresses hit/miss.
  always_comb begin
    if (score_clear) begin
      score_s = 8'h00;
    end else if (hit_s) begin
      score_s = bcd_inc(score_r);
`ifdef KEY_HIT_JUDGE_MISS_PENALTY_EN
    end else if (miss_s) begin
      score_s = bcd_dec(score_r);
`endif
    end else begin
      score_s = score_r;
    end
  end

  // State, score and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= IDLE;
      target_r <= 4'b0000;
      acc_r    <= 4'b0000;
      win_r    <= '0;
      score_r  <= 8'h00;
      hit_r    <= 1'b0;
      miss_r   <= 1'b0;
      armed_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      target_r <= target_s;
      acc_r    <= acc_s;
      win_r    <= win_s;
      score_r  <= score_s;
      hit_r    <= hit_s;
      miss_r   <= miss_s;
      armed_r  <= (state_s == ARMED);
    end
  end

  assign hit             = hit_r;
  assign miss            = miss_r;
  assign armed           = armed_r;
  assign score_1s_digit  = score_r[3:0];
  assign score_10s_digit = score_r[7:4];

endmodule

// File: tb/tb_key_hit_judge.sv
// Scoreboard bench for key_hit_judge: outcomes derived from per-prompt press-event lists.
module tb_key_hit_judge;

  localparam int D    = 4;
  localparam int W    = 100;
  localparam int LAT  = D + 3;   // drive cycle -> press event cycle
  localparam int HOLD = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] keys_n = 4'hF;
  logic       game_enable = 1'b1;
  logic       prompt_new = 1'b0;
  logic [3:0] prompt = 4'h0;
  logic       score_clear = 1'b0;
  logic       hit, miss, armed;
  logic [3:0] score_1s_digit, score_10s_digit;

  key_hit_judge #(.DEBOUNCE_CYCLES(D), .WINDOW_CYCLES(W)) dut (
    .clk(clk), .resetn(resetn), .keys_n(keys_n), .game_enable(game_enable),
    .prompt_new(prompt_new), .prompt(prompt), .score_clear(score_clear),
    .hit(hit), .miss(miss), .armed(armed),
    .score_1s_digit(score_1s_digit), .score_10s_digit(score_10s_digit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_hit;
    int cyc;
    int score;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   model_score = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int score_now();
    return int'(score_10s_digit) * 10 + int'(score_1s_digit);
  endfunction

  task automatic model_outcome(input bit h, input int c);
    if (h) model_score = (model_score >= 99) ? 99 : model_score + 1;
`ifdef KEY_HIT_JUDGE_MISS_PENALTY_EN
    else model_score = (model_score <= 0) ? 0 : model_score - 1;
`endif
    sb.push_back('{h, c, model_score});
  endtask

  // Monitor: every hit/miss pulse must match the oldest expected outcome.
  initial begin
    forever begin
      @(negedge clk);
      if (hit || miss) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pulse_unexpected: cycle %0d hit=%0b miss=%0b, expected no pulse", cyc, hit, miss);
        end else begin
          mon_e = sb.pop_front();
          chk("pulse_kind", int'({hit, miss}), mon_e.is_hit ? 2 : 1);
          chk("pulse_cycle", cyc, mon_e.cyc);
          chk("pulse_score", score_now(), mon_e.score);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // One prompt; oN = drive offset of KEY[N] relative to the strobe cycle, -1 = not pressed.
  task automatic run_prompt(input logic [3:0] tgt, input int o0, input int o1, input int o2, input int o3);
    int off[4];
    int p, oc, acc_t, endr, pr;
    bit oh, decided;
    off[0] = o0; off[1] = o1; off[2] = o2; off[3] = o3;
    @(negedge clk);
    p = cyc;
    prompt = tgt;
    prompt_new = 1'b1;
    decided = 1'b0;
    acc_t = 0;
    oh = 1'b0;
    oc = p + W;
    for (int t = p + 1; t <= p + W - 1; t++) begin
      if (!decided) begin
        pr = 0;
        for (int k = 0; k < 4; k++) if (off[k] >= 0 && p + off[k] + LAT == t) pr |= (1 << k);
        if ((pr & ~int'(tgt)) != 0) begin
          decided = 1'b1; oh = 1'b0; oc = t + 1;
        end else begin
          acc_t |= pr;
          if (acc_t == int'(tgt)) begin
            decided = 1'b1; oh = 1'b1; oc = t + 1;
          end
        end
      end
    end
    model_outcome(oh, oc);
    endr = oc - p + 2;
    for (int k = 0; k < 4; k++) if (off[k] >= 0 && off[k] + HOLD + LAT + 4 > endr) endr = off[k] + HOLD + LAT + 4;
    for (int r = 0; r <= endr; r++) begin
      if (r > 0) @(negedge clk);
      if (r == 1) prompt_new = 1'b0;
      for (int k = 0; k < 4; k++) keys_n[k] = !(off[k] >= 0 && r >= off[k] && r < off[k] + HOLD);
      if (p + r == oc - 1) chk("armed_before_judge", int'(armed), 1);
      if (p + r == oc) chk("armed_after_judge", int'(armed), 0);
    end
    keys_n = 4'hF;
  endtask

  // Second prompt 50 cycles into the first window; koff drives KEY[0] (-1 = none).
  task automatic run_overlap(input logic [3:0] a, input logic [3:0] b, input int koff);
    int p;
    @(negedge clk);
    p = cyc;
    prompt = a;
    prompt_new = 1'b1;
    model_outcome(koff >= 0, p + 51);
    model_outcome(1'b0, p + 50 + W);
    for (int r = 0; r <= 50 + W + 4; r++) begin
      if (r > 0) @(negedge clk);
      if (r == 1 || r == 51) prompt_new = 1'b0;
      if (r == 50) begin
        prompt = b;
        prompt_new = 1'b1;
      end
      keys_n[0] = !(koff >= 0 && r >= koff && r < koff + HOLD);
      if (r == 51) chk("armed_overlap", int'(armed), 1);
      if (r == 50 + W) chk("armed_overlap_end", int'(armed), 0);
    end
    keys_n = 4'hF;
  endtask

  task automatic run_bounce();
    int p;
    @(negedge clk);
    p = cyc;
    prompt = 4'b0001;
    prompt_new = 1'b1;
    model_outcome(1'b1, p + 25 + LAT + 1);
    for (int r = 0; r <= 60; r++) begin
      if (r > 0) @(negedge clk);
      if (r == 1) prompt_new = 1'b0;
      if (r < 5) keys_n[0] = 1'b1;
      else if (r < 25) keys_n[0] = (((r - 5) / 2) % 2) != 0;
      else if (r < 40) keys_n[0] = 1'b0;
      else keys_n[0] = 1'b1;
    end
  endtask

  task automatic run_clear_on_hit();
    int p;
    @(negedge clk);
    p = cyc;
    prompt = 4'b0001;
    prompt_new = 1'b1;
    for (int r = 0; r <= 35; r++) begin
      if (r > 0) @(negedge clk);
      if (r == 1) prompt_new = 1'b0;
      keys_n[0] = !(r >= 10 && r < 10 + HOLD);
      if (r == 17) begin
        chk("armed_before_clear", int'(armed), 1);
        score_clear = 1'b1;
      end
      if (r == 18) begin
        score_clear = 1'b0;
        model_score = 0;
        chk("score_after_clear", score_now(), 0);
        chk("armed_after_clear", int'(armed), 0);
      end
    end
  endtask

  task automatic run_disabled();
    int q;
    @(negedge clk);
    game_enable = 1'b0;
    prompt = 4'b0001;
    prompt_new = 1'b1;
    for (int r = 0; r <= 30; r++) begin
      if (r > 0) @(negedge clk);
      if (r == 1) prompt_new = 1'b0;
      keys_n[0] = !(r >= 2 && r < 2 + HOLD);
      if (r == 2) chk("armed_disabled", int'(armed), 0);
    end
    chk("score_held_disabled", score_now(), model_score);
    game_enable = 1'b1;
    @(negedge clk);
    q = cyc;
    prompt_new = 1'b1;
    for (int r = 0; r <= 50; r++) begin
      if (r > 0) @(negedge clk);
      if (r == 1) prompt_new = 1'b0;
      if (r == 10) chk("armed_enabled", int'(armed), 1);
      if (r == 20) game_enable = 1'b0;
      if (r == 21) chk("armed_drop_disable", int'(armed), 0);
      if (r == 40) game_enable = 1'b1;
      keys_n[0] = !(r >= 22 && r < 22 + HOLD);
    end
    chk("score_held_disable_mid", score_now(), model_score);
  endtask

  task automatic run_reset_mid();
    @(negedge clk);
    prompt = 4'b0001;
    prompt_new = 1'b1;
    @(negedge clk);
    prompt_new = 1'b0;
    repeat (20) @(negedge clk);
    chk("armed_before_reset", int'(armed), 1);
    chk("score_before_reset", score_now(), model_score);
    #2;
    resetn = 1'b0;
    #1;
    chk("reset_armed", int'(armed), 0);
    chk("reset_hit_miss", int'({hit, miss}), 0);
    chk("reset_score", score_now(), 0);
    model_score = 0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic do_clear();
    @(negedge clk);
    score_clear = 1'b1;
    @(negedge clk);
    score_clear = 1'b0;
    model_score = 0;
    chk("score_clear", score_now(), 0);
  endtask

  initial begin
    logic [3:0] t;
    int o[4];
    int common;
    repeat (2) @(negedge clk);
    chk("rst_hit", int'(hit), 0);
    chk("rst_miss", int'(miss), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_score", score_now(), 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    run_prompt(4'b0010, -1, 10, -1, -1);           // single hit
    run_prompt(4'b1111, 5, 15, 25, 35);            // chord
    run_prompt(4'b0001, -1, -1, 5, -1);            // wrong key
    run_prompt(4'b0110, -1, 20, 20, -1);           // simultaneous completion
    run_prompt(4'b0011, 20, -1, 20, -1);           // wrong + partial same cycle
    run_bounce();
    run_reset_mid();
    run_prompt(4'b0001, -1, -1, -1, -1);           // timeout
    run_prompt(4'b0001, W - 8, -1, -1, -1);        // hit on last window cycle beats expiry
    run_prompt(4'b0001, W - 7, -1, -1, -1);        // one cycle too late
    run_overlap(4'b0011, 4'b0100, -1);
    run_overlap(4'b0001, 4'b0100, 50 - LAT);
    run_prompt(4'b0100, -1, -1, 3, -1);
    run_clear_on_hit();
    run_prompt(4'b1000, -1, -1, -1, 4);
    run_disabled();

    do_clear();
    for (int i = 0; i < 100; i++) begin
      case (i % 4)
        0: run_prompt(4'b0001, 0, -1, -1, -1);
        1: run_prompt(4'b0010, -1, 0, -1, -1);
        2: run_prompt(4'b0100, -1, -1, 0, -1);
        default: run_prompt(4'b1000, -1, -1, -1, 0);
      endcase
    end
    chk("score_saturated", score_now(), 99);
    run_prompt(4'b0001, -1, -1, -1, -1);
    do_clear();
    run_prompt(4'b0001, -1, -1, -1, -1);           // miss at 00

    for (int n = 0; n < 30; n++) begin
      t = 4'($urandom_range(1, 15));
      for (int k = 0; k < 4; k++) begin
        if (t[k]) o[k] = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, W - 9)) : -1;
        else o[k] = ($urandom_range(0, 9) < 2) ? int'($urandom_range(0, W - 9)) : -1;
      end
      if ($urandom_range(0, 3) == 0) begin
        common = int'($urandom_range(0, W - 9));
        for (int k = 0; k < 4; k++) if (o[k] >= 0) o[k] = common;
      end
      run_prompt(t, o[0], o[1], o[2], o[3]);
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
